axon_spike_scheduler: RTL and testbench
=======================================

// Module: axon_spike_scheduler
// PURPOSE
//  Upstream driver of the synapse SRAM. On start, latches a 256-bit axon spike vector and scans it from axon 0 to 255.
//  For each spiking axon it issues one Wishbone read to the synapse matrix.
//  It captures the matrix's 32-bit neuron-connection word and presents it, with the axon index, to the neuron integrators.
//  Wishbone master; shares wb_clk_i/wb_rst_i with the synapse matrix.
// PARAMETERS
//  BASE_ADDR  32'h30000000  synapse SRAM base; request address = BASE_ADDR + 4*axon
//  NUM_AXONS  256           spike vector width / scan length
//  AXON_W     8             axon index width (clog2 NUM_AXONS)
//  TIMEOUT    15            max cycles in REQ without ack before abort
// PORTS
//  wb_clk_i       in   1          clock, rising edge
//  wb_rst_i       in   1          reset, asynchronous, active-high
//  start_i        in   1          pulse: latch spikes_i, begin scan (ignored while busy_o)
//  spikes_i       in   NUM_AXONS  spike vector, bit n = axon n fired
//  m_cyc_o        out  1          Wishbone cycle
//  m_stb_o        out  1          Wishbone strobe
//  m_we_o         out  1          always 0 (read only)
//  m_sel_o        out  4          always 4'hF
//  m_adr_o        out  32         byte address of requested row
//  m_ack_i        in   1          slave ack (may be held while cyc&stb high)
//  conn_i         in   32         slave connection word, valid while cyc&stb&!we
//  conn_valid_o   out  1          1-cycle pulse: conn_o/axon_idx_o valid
//  conn_o         out  32         captured connection word
//  axon_idx_o     out  AXON_W     axon of conn_o
//  busy_o         out  1          high from start accept until done_o
//  done_o         out  1          1-cycle pulse: scan complete
//  err_o          out  1          sticky: a request timed out; cleared on next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, ptr 0, pending 0, timeout ctr 0. Asserting reset mid-REQ drops cyc/stb immediately and abandons the scan.
//  States:
//  - IDLE: on start_i, pending<=spikes_i, ptr<=0, err_o<=0, busy_o<=1; go to SCAN.
//  - SCAN: one axon per cycle.
//      pending[ptr]=1: go to REQ (cyc=stb=1, adr=BASE_ADDR+{ptr,2'b00}, tmo<=0).
//      Else ptr==NUM_AXONS-1: go to DONE.
//      Else ptr++.
//  - REQ: cyc/stb held.
//      On the rising edge with m_ack_i=1: conn_o<=conn_i, axon_idx_o<=ptr, conn_valid_o<=1 (next cycle, 1 cycle only), cyc/stb<=0, go to RELEASE.
//      Else tmo++; at tmo==TIMEOUT-1: cyc/stb<=0, err_o<=1, no conn_valid_o, go to RELEASE.
//  - RELEASE: cyc/stb low; wait until m_ack_i==0.
//      Then ptr==NUM_AXONS-1: go to DONE.
//      Else ptr++, go to SCAN.
//      Required because slave ack stays high until cyc&stb fall.
//  - DONE: done_o=1 one cycle, busy_o<=0, go to IDLE.
//  Timing:
//  - The slave acks on the falling clock edge, so a zero-wait request completes in 1 REQ cycle.
//  - Minimum cost per spiking axon: SCAN+REQ+RELEASE = 3 cycles.
//  - Empty vector: done_o 257 cycles after start accept.
//  Rules:
//  - start_i while busy_o: ignored; spikes_i changes after latch have no effect.
//  - m_adr_o is stable for the whole REQ state. m_we_o/m_sel_o are constant.
//  - ptr never wraps; the scan ends after axon NUM_AXONS-1, including when that axon itself spikes.
//  - conn_o/axon_idx_o hold their last values between pulses.
// TESTING
//  1 Reset, no start -> all outputs 0 for 20 cycles; reset during REQ -> m_cyc_o/m_stb_o 0 same cycle, busy_o 0.
//  2 spikes bits {0,255}, slave row0=32'hA5A5_0001, row255=32'h8000_0003 -> m_adr 0x30000000 then 0x300003FC.
//    conn_valid pulses (idx0,A5A50001), (idx255,80000003); then done_o; no other stb.
//  3 spikes all zero -> no m_stb_o, done_o exactly 257 cycles after start, err_o 0.
//  4 spikes bit 7, slave never acks -> stb high 15 cycles then drops, err_o=1, no conn_valid, done_o follows.
//    A new start clears err_o.
//  5 spikes bits {3,4}, slave holds ack 2 extra cycles after stb drops -> no stb for axon 4 until ack low; two valid pulses in order.
//  6 start_i pulsed again mid-scan with different spikes -> ignored; results match first vector only; all 256 bits set -> 256 pulses, idx 0..255.

Source files
------------

// File: rtl/axon_spike_scheduler.sv
// Axon spike scheduler: latches a spike vector, walks it from axon 0 to
// NUM_AXONS-1 and, for every spiking axon, fetches that axon's connection
// word from the synapse SRAM over Wishbone and hands it to the integrators.
//
// Wishbone handshake: a request is open while m_cyc_o & m_stb_o are high.
// A transfer completes on the rising edge where m_ack_i is sampled high,
// and conn_i is captured on that same edge. cyc/stb then drop, and no new
// request opens until m_ack_i has been seen low, because this slave keeps
// ack asserted for a while after the strobe falls.
module axon_spike_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_AXONS = 256,
  parameter int          AXON_W    = 8,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [NUM_AXONS-1:0] spikes_i,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [31:0]          m_adr_o,
  input  logic                 m_ack_i,
  input  logic [31:0]          conn_i,
  output logic                 conn_valid_o,
  output logic [31:0]          conn_o,
  output logic [AXON_W-1:0]    axon_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [AXON_W-1:0] LAST_AXON = AXON_W'(NUM_AXONS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_REQ     = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_AXONS-1:0]  pending_q, pending_d;
  logic [AXON_W-1:0]     ptr_q, ptr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cyc_q, cyc_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           conn_q, conn_d;
  logic [AXON_W-1:0]     idx_q, idx_d;
  logic                  conn_valid_q, conn_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Next-state and next-output computation for the scan/fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    ptr_d        = ptr_q;
    tmo_d        = tmo_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    conn_d       = conn_q;
    idx_d        = idx_q;
    conn_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pending_d = spikes_i;
          ptr_d     = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pending_q[ptr_q]) begin
          cyc_d   = 1'b1;
          adr_d   = BASE_ADDR + {{(30-AXON_W){1'b0}}, ptr_q, 2'b00};
          tmo_d   = '0;
          state_d = S_REQ;
        end else if (ptr_q == LAST_AXON) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_REQ: begin
        if (m_ack_i) begin
          conn_d       = conn_i;
          idx_d        = ptr_q;
          conn_valid_d = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          // Slave is unresponsive: give up on this axon and flag it.
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!m_ack_i) begin
          if (ptr_q == LAST_AXON) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops the bus request at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      tmo_q        <= '0;
      cyc_q        <= 1'b0;
      adr_q        <= '0;
      conn_q       <= '0;
      idx_q        <= '0;
      conn_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      conn_q       <= conn_d;
      idx_q        <= idx_d;
      conn_valid_q <= conn_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign m_cyc_o      = cyc_q;
  assign m_stb_o      = cyc_q;
  assign m_we_o       = 1'b0;
  assign m_sel_o      = 4'hF;
  assign m_adr_o      = adr_q;
  assign conn_valid_o = conn_valid_q;
  assign conn_o       = conn_q;
  assign axon_idx_o   = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Bench for axon_spike_scheduler: a negedge-acking synapse SRAM model, a
// bus/output monitor with expected queues, a vector table of whole scans,
// and hand-written reset sequences.
module tb_axon_spike_scheduler;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [255:0] spikes_i = '0;
  logic         m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]   m_sel_o;
  logic [31:0]  m_adr_o;
  logic         m_ack_i;
  logic [31:0]  conn_i;
  logic         conn_valid_o;
  logic [31:0]  conn_o;
  logic [7:0]   axon_idx_o;
  logic         busy_o, done_o, err_o;

  axon_spike_scheduler dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .spikes_i(spikes_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_ack_i(m_ack_i), .conn_i(conn_i),
    .conn_valid_o(conn_valid_o), .conn_o(conn_o), .axon_idx_o(axon_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Clock and reset
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Synapse SRAM model: acks on the falling edge, optionally holds ack longer
  logic [31:0] mem [256];
  bit          slave_ack_en = 1'b1;
  int          slave_hold = 0;
  int          hold_cnt = 0;

  assign conn_i = (m_cyc_o && m_stb_o) ? mem[m_adr_o[9:2]] : 32'hDEAD_BEEF;

  always @(negedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_ack_i = 1'b0;
      hold_cnt = 0;
    end else if (m_cyc_o && m_stb_o && slave_ack_en) begin
      m_ack_i = 1'b1;
      hold_cnt = slave_hold;
    end else if (m_ack_i && hold_cnt > 0) begin
      hold_cnt--;
    end else begin
      m_ack_i = 1'b0;
    end
  end

  // Scoreboard: expected request addresses and expected {idx, conn} pulses
  logic [31:0] exp_adr_q[$];
  logic [39:0] exp_q[$];
  logic        stb_prev = 1'b0;
  logic [31:0] adr_prev = '0;
  int          run = 0;
  int          last_run = 0;
  int          pulse_cnt = 0;

  always begin
    @(posedge wb_clk_i);
    #1;
    if (m_stb_o && !stb_prev) begin
      if (exp_adr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL adr_unexpected: got %0h expected no request", m_adr_o);
      end else begin
        check("req_adr", m_adr_o, exp_adr_q.pop_front());
      end
      check("stb_while_ack", m_ack_i, 1'b0);
      check("we_sel", {m_we_o, m_sel_o, m_cyc_o}, {1'b0, 4'hF, 1'b1});
      run = 0;
    end
    if (m_stb_o && stb_prev && m_adr_o != adr_prev)
      check("adr_stable", m_adr_o, adr_prev);
    if (m_stb_o) run++;
    if (!m_stb_o && stb_prev) last_run = run;
    if (conn_valid_o) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_unexpected: got %0h expected none", {axon_idx_o, conn_o});
      end else begin
        check("conn_pulse", {axon_idx_o, conn_o}, exp_q.pop_front());
      end
    end
    stb_prev = m_stb_o;
    adr_prev = m_adr_o;
  end

  // Scan vector table
  typedef struct {
    logic [255:0] spikes;
    bit           ack_en;
    int           hold;
    bit           restart;
    logic [255:0] alt;
    int           exp_cycles;
    int           exp_pulses;
    int           exp_run;
    bit           exp_err;
  } vec_t;

  vec_t tbl [6];

  task automatic run_scan(input int vi, input vec_t v);
    int  cycles;
    bit  done_seen;
    slave_ack_en = v.ack_en;
    slave_hold = v.hold;
    last_run = 0;
    pulse_cnt = 0;
    for (int a = 0; a < 256; a++) begin
      if (v.spikes[a]) begin
        exp_adr_q.push_back(BASE + 32'(a) * 4);
        if (v.ack_en) exp_q.push_back({8'(a), mem[a]});
      end
    end
    @(negedge wb_clk_i);
    spikes_i = v.spikes;
    start_i = 1'b1;
    cycles = 0;
    done_seen = 1'b0;
    while (!done_seen && cycles < 2000) begin
      @(posedge wb_clk_i);
      #1;
      start_i = 1'b0;
      cycles++;
      if (cycles == 1) check($sformatf("v%0d_busy", vi), busy_o, 1'b1);
      if (v.restart && cycles == 5) begin
        spikes_i = v.alt;
        start_i = 1'b1;
      end
      if (done_o) done_seen = 1'b1;
    end
    check($sformatf("v%0d_done_seen", vi), done_seen, 1'b1);
    check($sformatf("v%0d_cycles", vi), cycles, v.exp_cycles);
    check($sformatf("v%0d_pulses", vi), pulse_cnt, v.exp_pulses);
    check($sformatf("v%0d_pulses_left", vi), exp_q.size(), 0);
    check($sformatf("v%0d_reqs_left", vi), exp_adr_q.size(), 0);
    check($sformatf("v%0d_err", vi), err_o, v.exp_err);
    check($sformatf("v%0d_stb_run", vi), last_run, v.exp_run);
    @(posedge wb_clk_i);
    #1;
    check($sformatf("v%0d_after_done", vi), {done_o, busy_o}, 2'b00);
    repeat (4) @(posedge wb_clk_i);
    #1;
    check($sformatf("v%0d_idle_err_held", vi), err_o, v.exp_err);
    exp_q.delete();
    exp_adr_q.delete();
  endtask

  initial begin
    logic [255:0] s;
    logic [255:0] alt;
    int           waited;

    for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i), 16'(i * 3 + 1)};
    mem[0] = 32'hA5A5_0001;
    mem[255] = 32'h8000_0003;

    // Reset, then idle with no start: every output stays low
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge wb_clk_i);
      #1;
      check("reset_idle", {m_cyc_o, m_stb_o, m_we_o, m_sel_o != 4'hF, m_adr_o, conn_valid_o,
                           conn_o, axon_idx_o, busy_o, done_o, err_o}, '0);
    end

    s = '0; s[0] = 1'b1; s[255] = 1'b1;
    tbl[0] = '{spikes: s, ack_en: 1, hold: 0, restart: 0, alt: '0,
               exp_cycles: 261, exp_pulses: 2, exp_run: 1, exp_err: 0};
    tbl[1] = '{spikes: '0, ack_en: 1, hold: 0, restart: 0, alt: '0,
               exp_cycles: 257, exp_pulses: 0, exp_run: 0, exp_err: 0};
    s = '0; s[7] = 1'b1;
    tbl[2] = '{spikes: s, ack_en: 0, hold: 0, restart: 0, alt: '0,
               exp_cycles: 273, exp_pulses: 0, exp_run: 15, exp_err: 1};
    s = '0; s[3] = 1'b1; s[4] = 1'b1;
    tbl[3] = '{spikes: s, ack_en: 1, hold: 2, restart: 0, alt: '0,
               exp_cycles: 265, exp_pulses: 2, exp_run: 1, exp_err: 0};
    s = '0; s[10] = 1'b1;
    alt = '0; alt[20] = 1'b1; alt[30] = 1'b1;
    tbl[4] = '{spikes: s, ack_en: 1, hold: 0, restart: 1, alt: alt,
               exp_cycles: 259, exp_pulses: 1, exp_run: 1, exp_err: 0};
    tbl[5] = '{spikes: '1, ack_en: 1, hold: 0, restart: 0, alt: '0,
               exp_cycles: 769, exp_pulses: 256, exp_run: 1, exp_err: 0};

    for (int i = 0; i < 6; i++) run_scan(i, tbl[i]);

    // Reset in the middle of a stalled request
    slave_ack_en = 1'b0;
    exp_adr_q.push_back(BASE + 32'h1C);
    @(negedge wb_clk_i);
    s = '0; s[7] = 1'b1;
    spikes_i = s;
    start_i = 1'b1;
    waited = 0;
    do begin
      @(posedge wb_clk_i);
      #1;
      start_i = 1'b0;
      waited++;
    end while (!m_stb_o && waited < 30);
    check("rst_req_reached", m_stb_o, 1'b1);
    @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_req_bus", {m_cyc_o, m_stb_o}, 2'b00);
    check("rst_mid_req_busy", busy_o, 1'b0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    slave_ack_en = 1'b1;
    repeat (10) @(posedge wb_clk_i);
    #1;
    check("rst_abandoned", {m_stb_o, busy_o, done_o, conn_valid_o}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
